vga_fb_axi_rsp: RTL and testbench
=================================

# vga_fb_axi_rsp

AXI4 read-only responder serving an on-chip framebuffer SRAM to the VGA controller's AXI4 fetch master. It accepts one AR burst at a time, reads 64-bit words from internal SRAM and returns them on the R channel with `rlast` on the final beat. It tolerates arbitrary `rready` backpressure without dropping or duplicating beats. A simple host write port fills the framebuffer; the AW/W/B channels are out of scope.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI address width
- `ID_WIDTH`, 4, AXI ID width
- `MEM_DEPTH`, 4096, framebuffer depth in 64-bit words (power of 2)
- `BASE_ADDR`, 32'h0, byte address of word 0

Ports:
- `clk_i`  in  1  single clock; all logic synchronous to it
- `rst_i`  in  1  synchronous, active-high reset
- `arid_i`  in  ID_WIDTH  burst ID
- `araddr_i`  in  ADDR_WIDTH  start byte address
- `arlen_i`  in  8  beats minus 1
- `arsize_i`  in  3  beat size
- `arburst_i`  in  2  burst type
- `arvalid_i`  in  1  AR valid
- `arready_o`  out  1  AR ready
- `rid_o`  out  ID_WIDTH  echoed `arid`
- `rdata_o`  out  64  read data
- `rresp_o`  out  2  OKAY=2'b00, SLVERR=2'b10
- `rlast_o`  out  1  last beat
- `rvalid_o`  out  1  R valid
- `rready_i`  in  1  R ready
- `wr_en_i`  in  1  host write strobe
- `wr_addr_i`  in  $clog2(MEM_DEPTH)  host word address
- `wr_data_i`  in  64  host write data

## Operation
- States: IDLE, BURST.
  - IDLE: `arready_o`=1. On AR handshake, latch id, word index `(araddr-BASE_ADDR)>>3`, beat count `arlen+1`, burst type; go to BURST.
  - BURST: `arready_o`=0. Issue one SRAM read per cycle while the issued-but-not-returned beat count plus skid occupancy is < 2 and beats remain. Move to IDLE on the cycle the `rlast` beat handshakes.
- Address step: INCR adds 1 word per beat; FIXED holds the address.
- Output path: 2-entry skid FIFO holds {data, resp, last}. `rvalid_o` = FIFO not empty. Pop occurs on `rvalid_o && rready_i`.
- `rid_o` equals the latched ID for every beat of the burst.
- `rlast_o`=1 only on beat `arlen+1`. `arlen`=0 gives a single beat with `rlast`.
- SRAM is read-first. If a host write and a burst read hit the same word in the same cycle, the read returns the old data. Host writes are accepted in any state.

## Timing
- Reset: `arready_o`=0 while `rst_i`=1, and 1 on the first cycle after release. `rvalid_o`, `rlast_o`=0; `rdata_o`, `rresp_o`, `rid_o`=0. Skid buffer emptied.
- AR handshake at cycle T → SRAM read issued at T+1 → first `rvalid_o` at T+2.
- With `rready_i` held high: 1 beat/cycle. An N-beat burst ends with `rlast` at T+1+N.
- `rready_i` low: `rvalid_o`, `rdata_o`, `rresp_o`, `rlast_o`, `rid_o` are held stable. Reads stop once 2 beats are outstanding, so there is no overflow. Full rate resumes the cycle after `rready_i` rises.
- After the `rlast` handshake at cycle L, `arready_o`=1 at L+1. The minimum gap between bursts is one cycle.
- `rst_i` mid-burst: the burst is abandoned, the FIFO is flushed and the state returns to IDLE. No further beats are issued.

## Configuration
- `VGA_FB_RSP_ERR_EN` defined: responses are checked for legality.
  - `arsize`≠3, `arburst`=WRAP/reserved, or any beat whose word index is outside [0, MEM_DEPTH-1] returns `rresp`=SLVERR with `rdata`=0.
  - The burst length and `rlast` are still honoured.
- Undefined: every beat returns OKAY. The word index wraps modulo MEM_DEPTH, and WRAP/reserved bursts are treated as INCR.

## Test plan
- Single-beat read: host writes 64'hDEAD_BEEF_0123_4567 to word 5; AR addr=BASE+0x28, len=0, id=3 → one beat with that data, `rid`=3, `rresp`=0, `rlast`=1, `rvalid` at T+2.
- INCR burst, `rready` held high: words 0..15 = index; AR len=15 → 16 consecutive beats with data 0..15, `rlast` only on beat 16, `arready`=1 the cycle after.
- Backpressure: same burst with `rready` toggled randomly (~50%) → the data sequence is exactly 0..15, and outputs are stable whenever valid && !ready.
- FIXED burst len=3 at word 7 (holding 0xAA) → four beats of 0xAA.
- With `VGA_FB_RSP_ERR_EN`: INCR len=3 starting at word MEM_DEPTH-2 → beats 1-2 OKAY with data, beats 3-4 SLVERR with data 0, `rlast` on beat 4. Without the macro the same request returns words 4094, 4095, 0, 1, all OKAY.
- Reset mid-burst: assert `rst_i` after beat 3 of a 16-beat burst → `rvalid`=0 the next cycle, `arready`=1 after release, and a new burst returns correct data.

Source files
------------

// File: rtl/vga_fb_axi_rsp.sv
// ---------------------------------------------------------------------------
// vga_fb_axi_rsp
//
// AXI4 read-only responder in front of the on-chip framebuffer SRAM. One AR
// burst is accepted at a time. Words are read from the SRAM directly into a
// 2-entry skid FIFO and returned on the R channel, with rlast on the final
// beat. Arbitrary rready backpressure is absorbed by the skid FIFO. A simple
// host write port fills the framebuffer.
//
// Optional feature (compile-time macro VGA_FB_RSP_ERR_EN):
//   defined   - arsize != 3, WRAP/reserved bursts, and beats whose word index
//               is outside the framebuffer return SLVERR with zero data.
//   undefined - every beat is OKAY, the word index wraps modulo MEM_DEPTH,
//               and WRAP/reserved bursts behave as INCR.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   ar*_i / arready_o      AXI4 read address channel
//   r*_o / rready_i        AXI4 read data channel
//   wr_en_i/addr_i/data_i  host framebuffer write port (any state)
// ---------------------------------------------------------------------------
module vga_fb_axi_rsp #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ID_WIDTH-1:0]          arid_i,
    input  logic [ADDR_WIDTH-1:0]        araddr_i,
    input  logic [7:0]                   arlen_i,
    input  logic [2:0]                   arsize_i,
    input  logic [1:0]                   arburst_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [ID_WIDTH-1:0]          rid_o,
    output logic [63:0]                  rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rlast_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
    input  logic [63:0]                  wr_data_i
);

    localparam int AW = $clog2(MEM_DEPTH);  // framebuffer word address width
    localparam int WW = ADDR_WIDTH - 3;     // full word-index width

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [WW-1:0]       widx_q;    // word index of the next beat to read
    logic [8:0]          beats_q;   // beats still to be read from the SRAM
    logic                fixed_q;

    // Skid FIFO: storage plus pointers/occupancy.
    logic [63:0] fifo_data [2];
    logic [1:0]  fifo_resp [2];
    logic        fifo_last [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic [63:0] mem [MEM_DEPTH];

    logic                  ar_hs;
    logic                  pop;
    logic                  issue;
    logic                  beat_last;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] ar_offset;

    // NOTE: arready is decoded from the registered state and masked by the
    // synchronous reset, so it is low throughout reset and high on the very
    // first cycle after release without an extra pipeline stage.
    assign arready_o = (state_q == S_IDLE) && !rst_i;
    assign ar_hs     = arvalid_i && arready_o;

    assign rvalid_o  = (count_q != 2'd0);
    assign pop       = rvalid_o && rready_i;

    // A read lands in the FIFO on the next edge, so nothing is ever in
    // flight between the SRAM and the FIFO: only FIFO occupancy throttles.
    assign issue     = (state_q == S_BURST) && (beats_q != 9'd0) && !count_q[1];
    assign beat_last = (beats_q == 9'd1);

    assign ar_offset = araddr_i - BASE_ADDR;

`ifdef VGA_FB_RSP_ERR_EN
    logic bad_req_q;  // illegal size or burst type for the whole burst

    // Any set bit above the framebuffer width means the word is out of range;
    // addresses below BASE_ADDR wrap to huge indices and are caught too.
    assign beat_err = bad_req_q || (widx_q[WW-1:AW] != '0);

    logic unused_ok;
    assign unused_ok = ^ar_offset[2:0];
`else
    assign beat_err = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{ar_offset[2:0], arsize_i, widx_q[WW-1:AW]};
`endif

    // Outputs are forced to zero while the FIFO is empty (including reset).
    assign rdata_o = rvalid_o ? fifo_data[rd_ptr_q] : 64'd0;
    assign rresp_o = rvalid_o ? fifo_resp[rd_ptr_q] : RESP_OKAY;
    assign rlast_o = rvalid_o ? fifo_last[rd_ptr_q] : 1'b0;
    assign rid_o   = id_q;

    // Control: FSM, burst bookkeeping and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            widx_q    <= '0;
            beats_q   <= '0;
            fixed_q   <= 1'b0;
`ifdef VGA_FB_RSP_ERR_EN
            bad_req_q <= 1'b0;
`endif
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_hs) begin
                        id_q      <= arid_i;
                        widx_q    <= ar_offset[ADDR_WIDTH-1:3];
                        beats_q   <= {1'b0, arlen_i} + 9'd1;
                        fixed_q   <= (arburst_i == 2'b00);
`ifdef VGA_FB_RSP_ERR_EN
                        bad_req_q <= (arsize_i != 3'd3) || arburst_i[1];
`endif
                        state_q   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (issue) begin
                        beats_q <= beats_q - 9'd1;
                        if (!fixed_q) widx_q <= widx_q + WW'(1);
                    end
                    if (pop && fifo_last[rd_ptr_q]) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (issue) wr_ptr_q <= ~wr_ptr_q;
            if (pop)   rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, issue} - {1'b0, pop};
        end
    end

    // NOTE: the SRAM and the FIFO payload are plain storage with no reset;
    // the reset pointers and occupancy already make stale contents invisible.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    end

    // Read-first: this edge samples mem before the host write above lands.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            fifo_data[wr_ptr_q] <= beat_err ? 64'd0 : mem[widx_q[AW-1:0]];
            fifo_resp[wr_ptr_q] <= beat_err ? RESP_SLVERR : RESP_OKAY;
            fifo_last[wr_ptr_q] <= beat_last;
        end
    end

endmodule

// File: tb/tb_vga_fb_axi_rsp.sv
module tb_vga_fb_axi_rsp;

    localparam int DEPTH = 4096;
`ifdef VGA_FB_RSP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [7:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        wr_en_i;
    logic [11:0] wr_addr_i;
    logic [63:0] wr_data_i;

    vga_fb_axi_rsp dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arlen_i   (arlen_i),
        .arsize_i  (arsize_i),
        .arburst_i (arburst_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rlast_o   (rlast_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          rmode;      // 0: rready high, 1: random rready
        bit          pre_wr;     // host write before the burst
        logic [11:0] pre_waddr;
        logic [63:0] pre_wdata;
        bit          coll;       // host write to the start word on the read-issue cycle
        logic [63:0] coll_data;
        logic [65:0] exp_first;  // {rresp, rdata} of the first beat
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t       sb[$];
    logic [63:0] model_mem [DEPTH];
    vec_t        vecs [11];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rmode = 0;

    // Monitor state.
    int           ar_cyc, first_cyc, last_cyc, beats_seen = 0;
    bit           first_pending = 0, hold_prev = 0, ar_next_chk = 0;
    logic [65:0]  first_beat;
    logic [127:0] held_snap;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        rready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            rready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // R-channel monitor and scoreboard consumer.
    initial forever begin
        beat_t got, exp_b;
        @(negedge clk_i);
        if (rst_i) begin
            hold_prev     = 0;
            ar_next_chk   = 0;
            first_pending = 0;
        end else begin
            if (ar_next_chk) begin
                check("arready_after_last", arready_o, 1'b1);
                ar_next_chk = 0;
            end
            if (arvalid_i && arready_o) begin
                ar_cyc        = cyc;
                first_pending = 1;
            end
            if (hold_prev)
                check("hold_stable", {rvalid_o, rid_o, rresp_o, rlast_o, rdata_o}, held_snap);
            if (rvalid_o && first_pending) begin
                first_cyc     = cyc;
                first_beat    = {rresp_o, rdata_o};
                first_pending = 0;
            end
            if (rvalid_o && rready_i) begin
                got = '{id: rid_o, resp: rresp_o, last: rlast_o, data: rdata_o};
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", got);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", got, exp_b);
                end
                beats_seen++;
                if (rlast_o) begin
                    last_cyc    = cyc;
                    ar_next_chk = 1;
                end
            end
            hold_prev = rvalid_o && !rready_i;
            held_snap = {56'd0, rvalid_o, rid_o, rresp_o, rlast_o, rdata_o};
        end
    end

    task automatic host_write(input logic [11:0] a, input logic [63:0] d);
        @(posedge clk_i);
        #1;
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        model_mem[a] = d;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
    endtask

    // Reference model of one burst: pushes every expected beat.
    task automatic push_expected(input vec_t v);
        logic [28:0] w, idx;
        bit          err;
        beat_t       b;
        w = v.addr[31:3];
        for (int i = 0; i <= int'(v.len); i++) begin
            idx = (v.burst == 2'b00) ? w : w + 29'(i);
            err = ERR && ((v.size != 3'd3) || v.burst[1] || (idx >= 29'(DEPTH)));
            b.id   = v.id;
            b.resp = err ? 2'b10 : 2'b00;
            b.data = err ? 64'd0 : model_mem[idx[11:0]];
            b.last = (i == int'(v.len));
            sb.push_back(b);
        end
    endtask

    task automatic send_ar(input vec_t v);
        int n;
        @(posedge clk_i);
        #1;
        arid_i    = v.id;
        araddr_i  = v.addr;
        arlen_i   = v.len;
        arsize_i  = v.size;
        arburst_i = v.burst;
        arvalid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!arready_o && n < 20);
        check("arready_wait", arready_o, 1'b1);
        @(posedge clk_i);
        #1;
        arvalid_i = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int n;
        if (v.pre_wr) host_write(v.pre_waddr, v.pre_wdata);
        rmode = v.rmode;
        push_expected(v);
        send_ar(v);
        if (v.coll) begin
            // Now in the cycle after the handshake: the read issues here.
            wr_en_i   = 1'b1;
            wr_addr_i = v.addr[14:3];
            wr_data_i = v.coll_data;
            model_mem[v.addr[14:3]] = v.coll_data;
            @(posedge clk_i);
            #1;
            wr_en_i = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_left", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk_i);
        check("first_latency", first_cyc - ar_cyc, 2);
        check("first_beat", first_beat, v.exp_first);
        if (v.rmode == 0) check("last_cycle", last_cyc - ar_cyc, int'(v.len) + 2);
        rmode = 0;
    endtask

    initial begin
        vec_t v;
        int   base, n;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   base, n;

        //       id     addr          len    burst  size  rm pre   waddr  wdata                    coll  cdata                    exp_first
        vecs[0]  = '{4'd3,  32'h0000_0028, 8'd0,  2'b01, 3'd3, 0, 1'b1, 12'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0, {2'b00, 64'hDEAD_BEEF_0123_4567}};
        vecs[1]  = '{4'd1,  32'h0000_0000, 8'd15, 2'b01, 3'd3, 0, 1'b1, 12'd5, 64'd5,                  1'b0, 64'd0, {2'b00, 64'd0}};
        vecs[2]  = '{4'd2,  32'h0000_0000, 8'd15, 2'b01, 3'd3, 1, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, {2'b00, 64'd0}};
        vecs[3]  = '{4'd4,  32'h0000_0038, 8'd3,  2'b00, 3'd3, 0, 1'b1, 12'd7, 64'hAA,                 1'b0, 64'd0, {2'b00, 64'hAA}};
        vecs[4]  = '{4'd5,  32'h0000_7FF0, 8'd3,  2'b01, 3'd3, 0, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, {2'b00, 64'd4094}};
        vecs[5]  = '{4'd6,  32'h0000_0040, 8'd1,  2'b10, 3'd3, 0, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, ERR ? {2'b10, 64'd0} : {2'b00, 64'd8}};
        vecs[6]  = '{4'd7,  32'h0000_0048, 8'd0,  2'b01, 3'd2, 0, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, ERR ? {2'b10, 64'd0} : {2'b00, 64'd9}};
        vecs[7]  = '{4'd15, 32'h0010_0000, 8'd1,  2'b01, 3'd3, 1, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, ERR ? {2'b10, 64'd0} : {2'b00, 64'd0}};
        vecs[8]  = '{4'd9,  32'h0000_0080, 8'd3,  2'b01, 3'd3, 1, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, {2'b00, 64'd16}};
        vecs[9]  = '{4'd8,  32'h0000_0048, 8'd0,  2'b01, 3'd3, 0, 1'b0, 12'd0, 64'd0,                  1'b1, 64'h1234_5678_9ABC_DEF0, {2'b00, 64'd9}};
        vecs[10] = '{4'd11, 32'h0000_0048, 8'd0,  2'b01, 3'd3, 0, 1'b0, 12'd0, 64'd0,                  1'b0, 64'd0, {2'b00, 64'h1234_5678_9ABC_DEF0}};

        rst_i     = 1'b1;
        arid_i    = '0;
        araddr_i  = '0;
        arlen_i   = '0;
        arsize_i  = 3'd3;
        arburst_i = 2'b01;
        arvalid_i = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", {arready_o, rvalid_o, rlast_o, rresp_o, rid_o, rdata_o}, '0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("arready_after_reset", arready_o, 1'b1);

        // Fill the framebuffer with word i = i.
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk_i);
            #1;
            wr_en_i   = 1'b1;
            wr_addr_i = 12'(i);
            wr_data_i = 64'(i);
            model_mem[i] = 64'(i);
        end
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;

        for (int k = 0; k < 11; k++) run_burst(vecs[k]);

        // Reset in the middle of a 16-beat burst.
        v = '{4'd10, 32'h0, 8'd15, 2'b01, 3'd3, 0, 1'b0, 12'd0, 64'd0, 1'b0, 64'd0, {2'b00, 64'd0}};
        push_expected(v);
        base = beats_seen;
        send_ar(v);
        n = 0;
        while (beats_seen < base + 3 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        check("beats_before_reset", beats_seen - base, 3);
        #2;
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_mid_outputs", {arready_o, rvalid_o, rlast_o, rdata_o}, '0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_arready", {arready_o, rvalid_o}, 2'b10);
        base = 0;
        repeat (4) begin
            @(negedge clk_i);
            base += int'(rvalid_o);
        end
        check("no_beats_after_rst", base, 0);

        v = '{4'd12, 32'h0000_0050, 8'd3, 2'b01, 3'd3, 0, 1'b0, 12'd0, 64'd0, 1'b0, 64'd0, {2'b00, 64'd10}};
        run_burst(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
